// File: rtl/serial_sub_arbiter.sv
// serial_sub_arbiter: round-robin share of one bit-serial full-subtractor slice between two requesters
module serial_sub_arbiter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  input  logic             req1,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  output logic             ack0,
  output logic             ack1,
  output logic             busy,
  output logic             done,
  output logic             gid,
  output logic [WIDTH-1:0] diff,
  output logic             bout
);
  localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, FIN = 2'd2;
  localparam int CW = $clog2(WIDTH);
  logic [1:0] state;
  logic last_grant, brw, win, d, bo;
  logic [WIDTH-1:0] sa, sb, res;
  logic [CW-1:0] cnt;
  // winner selection and the shared subtractor slice
  always_comb begin
    win = (req0 & req1) ? ~last_grant : req1;
    d = sa[0] ^ sb[0] ^ brw;
    bo = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & brw);
  end
  assign busy = state != IDLE;
  // arbitration, serial datapath and registered result outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      last_grant <= 1'b1;
      ack0 <= 1'b0;
      ack1 <= 1'b0;
      done <= 1'b0;
      gid <= 1'b0;
      diff <= '0;
      bout <= 1'b0;
      brw <= 1'b0;
      cnt <= '0;
      sa <= '0;
      sb <= '0;
      res <= '0;
    end else begin
      ack0 <= 1'b0;
      ack1 <= 1'b0;
      done <= 1'b0;
      if (state == IDLE && (req0 | req1)) begin
        sa <= win ? a1 : a0;
        sb <= win ? b1 : b0;
        brw <= 1'b0;
        cnt <= '0;
        gid <= win;
        last_grant <= win;
        ack0 <= ~win;
        ack1 <= win;
        state <= RUN;
      end else if (state == RUN) begin
        res <= {d, res[WIDTH-1:1]};
        sa <= sa >> 1;
        sb <= sb >> 1;
        brw <= bo;
        cnt <= cnt + 1'b1;
        if (cnt == CW'(WIDTH - 1)) state <= FIN;
      end else if (state == FIN) begin
        done <= 1'b1;
        diff <= res;
        bout <= brw;
        state <= IDLE;
      end
    end
  end
endmodule
